// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: index width helper and grant index type.
package rr_arbiter_pkg;

  localparam int unsigned MAX_INPUTS = 64;
  localparam int unsigned MAX_IDX_W  = 6;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wide enough to hold any legal requester index.
  typedef logic [MAX_IDX_W-1:0] grant_idx_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating priority picker: first set request at or after ptr, wrapping modulo ninputs.
module rr_arbiter_pick
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned ninputs = 8,
  parameter int unsigned iw      = idx_width(ninputs)
) (
  input  logic [ninputs-1:0] req,
  input  logic [iw-1:0]      ptr,
  input  logic               en,
  output logic [ninputs-1:0] gnt_c,
  output logic [iw-1:0]      idx_c,
  output logic               any_c
);

  localparam int unsigned SW = iw + 1;

  logic [2*ninputs-1:0] req_dbl;
  logic [2*ninputs-1:0] rot_dbl;
  logic [ninputs-1:0]   rot;
  logic [iw-1:0]        off;
  logic                 found;
  logic [SW-1:0]        sum;

  always_comb begin
    // Rotate so that the ptr position becomes bit 0.
    req_dbl = {req, req};
    rot_dbl = req_dbl >> ptr;
    rot     = rot_dbl[ninputs-1:0];

    // Lowest set bit of the rotated vector wins.
    off   = '0;
    found = 1'b0;
    for (int i = int'(ninputs) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = iw'(i);
        found = 1'b1;
      end
    end

    // Rotate back to an absolute index; ptr < ninputs keeps this a single subtract.
    sum = SW'(ptr) + SW'(off);
    if (sum >= SW'(ninputs)) begin
      sum = sum - SW'(ninputs);
    end
    idx_c = sum[iw-1:0];

    any_c = found && en;
    gnt_c = '0;
    if (any_c) begin
      gnt_c[idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-to-1 round-robin arbiter into a one-entry output register.
// Define RR_ARBITER_TAG_EN to prepend the granted source index to ostream_msg.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int unsigned nbits   = 32,
  parameter  int unsigned ninputs = 8,
  localparam int unsigned iw      = idx_width(ninputs),
`ifdef RR_ARBITER_TAG_EN
  localparam int unsigned ow      = nbits + iw
`else
  localparam int unsigned ow      = nbits
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val [0:ninputs-1],
  input  logic [nbits-1:0] istream_msg [0:ninputs-1],
  output logic             istream_rdy [0:ninputs-1],
  output logic             ostream_val,
  output logic [ow-1:0]    ostream_msg,
  input  logic             ostream_rdy
);

  logic               full;
  logic [ow-1:0]      msg_q;
  logic [iw-1:0]      ptr;

  logic               accept_c;
  logic [ninputs-1:0] req_c;
  logic [ninputs-1:0] gnt_c;
  logic [iw-1:0]      gidx_c;
  logic               gany_c;
  logic [ow-1:0]      msg_d_c;

  // The register can take a new message when empty or draining this cycle.
  assign accept_c = !full || ostream_rdy;

  always_comb begin
    for (int i = 0; i < int'(ninputs); i++) begin
      req_c[i]       = istream_val[i];
      istream_rdy[i] = gnt_c[i];
    end
  end

  rr_arbiter_pick #(
    .ninputs (ninputs),
    .iw      (iw)
  ) u_pick (
    .req   (req_c),
    .ptr   (ptr),
    .en    (accept_c && !reset),
    .gnt_c (gnt_c),
    .idx_c (gidx_c),
    .any_c (gany_c)
  );

`ifdef RR_ARBITER_TAG_EN
  assign msg_d_c = {gidx_c, istream_msg[gidx_c]};
`else
  assign msg_d_c = istream_msg[gidx_c];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      full  <= 1'b0;
      msg_q <= '0;
      ptr   <= '0;
    end else if (gany_c) begin
      full  <= 1'b1;
      msg_q <= msg_d_c;
      ptr   <= (gidx_c == iw'(ninputs - 1)) ? '0 : gidx_c + iw'(1);
    end else if (ostream_rdy) begin
      full  <= 1'b0;
    end
  end

  assign ostream_val = full;
  assign ostream_msg = msg_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed table-driven bench for rr_arbiter (8 inputs, 32-bit payload).
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  localparam int unsigned NB = 32;
  localparam int unsigned NI = 8;
`ifdef RR_ARBITER_TAG_EN
  localparam int unsigned OW = NB + 3;
`else
  localparam int unsigned OW = NB;
`endif

  logic          clk;
  logic          reset;
  logic          istream_val [0:NI-1];
  logic [NB-1:0] istream_msg [0:NI-1];
  logic          istream_rdy [0:NI-1];
  logic          ostream_val;
  logic [OW-1:0] ostream_msg;
  logic          ostream_rdy;

  rr_arbiter #(.nbits(NB), .ninputs(NI)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_msg (istream_msg),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_msg (ostream_msg),
    .ostream_rdy (ostream_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] val;
    logic       ordy;
    logic [7:0] rdy;
    logic       oval;
    int         src;
    grant_idx_t ptr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [OW-1:0] exp_msg(input int idx, input logic [NB-1:0] p);
`ifdef RR_ARBITER_TAG_EN
    return OW'({3'(idx), p});
`else
    return OW'(p);
`endif
  endfunction

  function automatic logic [7:0] rdy_vec();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = istream_rdy[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] val, input logic ordy,
                     input logic [7:0] rdy, input logic oval, input int src, input int p);
    vec_t v;
    v.rst = rst; v.val = val; v.ordy = ordy; v.rdy = rdy;
    v.oval = oval; v.src = src; v.ptr = grant_idx_t'(p);
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    ostream_rdy = 1'b0;
    for (int i = 0; i < int'(NI); i++) begin
      istream_val[i] = 1'b0;
      istream_msg[i] = NB'(32'h100 + i);
    end

    // Reset held two cycles with every input requesting
    add(1, 8'hFF, 1, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 8'h00, 0, 0, 0);
    // Saturation: 0..7 then 0 again
    for (int k = 0; k < 9; k++)
      add(0, 8'hFF, 1, 8'(1 << (k % 8)), 1, k % 8, (k + 1) % 8);
    // Sparse/wrap: steer ptr to 3, then alternate 7 and 2
    add(0, 8'h04, 1, 8'h04, 1, 2, 3);
    add(0, 8'h84, 1, 8'h80, 1, 7, 0);
    add(0, 8'h84, 1, 8'h04, 1, 2, 3);
    add(0, 8'h84, 1, 8'h80, 1, 7, 0);
    // Backpressure holds message and ptr, blocks grants
    for (int k = 0; k < 4; k++)
      add(0, 8'hFF, 0, 8'h00, 1, 7, 0);
    // Release: drain and new grant in the same cycle
    add(0, 8'hFF, 1, 8'h01, 1, 0, 1);
    // Drain only, idle, then fill an empty register under ostream_rdy=0
    add(0, 8'h00, 1, 8'h00, 0, 0, 1);
    add(0, 8'h00, 0, 8'h00, 0, 0, 1);
    add(0, 8'h02, 0, 8'h02, 1, 1, 2);
    add(0, 8'hFF, 0, 8'h00, 1, 1, 2);
    // Reset while full under backpressure, then first grant goes to 0
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 1, 8'h01, 1, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset       = tbl[i].rst;
      ostream_rdy = tbl[i].ordy;
      for (int j = 0; j < 8; j++) istream_val[j] = tbl[i].val[j];
      #1;
      chk($sformatf("v%0d.rdy", i), 64'(rdy_vec()), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.oval", i), 64'(ostream_val), 64'(tbl[i].oval));
      if (tbl[i].oval)
        chk($sformatf("v%0d.omsg", i), 64'(ostream_msg),
            64'(exp_msg(tbl[i].src, NB'(32'h100 + tbl[i].src))));
      chk($sformatf("v%0d.ptr", i), 64'(dut.ptr), 64'(tbl[i].ptr));
    end

    // Single requester: input 5 streams 10 distinct messages back to back
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 1'b0;
      ostream_rdy = 1'b1;
      for (int j = 0; j < 8; j++) istream_val[j] = (j == 5);
      istream_msg[5] = NB'(32'hA000 + k);
      #1;
      chk($sformatf("solo%0d.rdy", k), 64'(rdy_vec()), 64'h20);
      @(posedge clk);
      #1;
      chk($sformatf("solo%0d.oval", k), 64'(ostream_val), 64'h1);
      chk($sformatf("solo%0d.omsg", k), 64'(ostream_msg), 64'(exp_msg(5, NB'(32'hA000 + k))));
      chk($sformatf("solo%0d.ptr", k), 64'(dut.ptr), 64'd6);
    end

    // Let the last message drain
    @(negedge clk);
    for (int j = 0; j < 8; j++) istream_val[j] = 1'b0;
    @(posedge clk);
    #1;
    chk("final.oval", 64'(ostream_val), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- N-to-1 round-robin arbiter that merges `ninputs` val/rdy streams into one registered output stream.
- It is the converging counterpart of the stream router: it shares one downstream consumer (a router input, accelerator or serializer) among several requesters.
- Fairness is round-robin. Each accepted message is captured in a one-entry output register.

Parameters:
- nbits, 32, payload width per input message.
- ninputs, 8, number of requesters; legal range 2..64.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- istream_val  input  1 x ninputs (unpacked [0:ninputs-1])  per-requester valid.
- istream_msg  input  nbits x ninputs (unpacked [0:ninputs-1])  per-requester payload.
- istream_rdy  output  1 x ninputs (unpacked [0:ninputs-1])  per-requester ready (grant).
- ostream_val  output  1  output valid.
- ostream_msg  output  OW (see Optional Feature)  output payload.
- ostream_rdy  input  1  downstream ready.

Behaviour:
- Reset: ostream_val=0, ostream_msg=0, round-robin pointer ptr=0, all istream_rdy=0 during the reset cycle.
- Reset asserted mid-operation drops any held output message.
- State: output register (full flag plus message) and ptr, which is $clog2(ninputs) bits.
- accept = !full || ostream_rdy. A new message may enter in the same cycle an old one drains.
- Grant: when accept=1, scan indices ptr, ptr+1, ..., ptr+ninputs-1 (mod ninputs). The first index with istream_val=1 is granted.
  - istream_rdy[g]=1 for the granted index only; all other istream_rdy=0.
  - If accept=0 or no valid input, all istream_rdy=0.
- istream_rdy depends combinationally on istream_val and ostream_rdy. Producers must not make val depend on rdy.
- On a transfer (istream_val[g] && istream_rdy[g]):
  - the register loads istream_msg[g] (plus tag if enabled);
  - full<=1;
  - ptr<=(g+1) mod ninputs. Wrap: g=ninputs-1 gives ptr=0.
- Non-power-of-two ninputs: ptr never takes values >= ninputs.
- Drain only (ostream_val && ostream_rdy, no new grant): full<=0.
- Drain and grant in the same cycle: full stays 1 and the message is replaced. Sustained throughput is 1 message/cycle.
- ptr holds when no transfer occurs.
- ostream_val=full.
- ostream_msg is stable while ostream_val=1 && ostream_rdy=0. Backpressure holds it and blocks all grants.
- Latency: input transfer at cycle t gives ostream_val at t+1.
- Fairness: with all inputs continuously valid and ostream_rdy=1, the grant order is 0,1,...,N-1,0,... Each requester waits at most ninputs-1 grants.

Optional Feature:
- Macro: RR_ARBITER_TAG_EN.
- Defined:
  - OW = nbits + $clog2(ninputs);
  - ostream_msg[OW-1 : nbits] = granted index g, and ostream_msg[nbits-1:0] = payload;
  - the source index sits in the MSBs, the field a downstream router decodes for its select.
- Undefined:
  - OW = nbits;
  - ostream_msg = payload only, and the source index is discarded.

Decomposition:
- Package rr_arbiter_pkg holds:
  - localparam function for the index width (`$clog2` with a minimum of 1);
  - a typedef for the grant index.
- Sub-module rr_arbiter_pick (combinational):
  - inputs: req vector, ptr, en;
  - outputs: one-hot grant vector and encoded grant index;
  - implemented by rotating the request vector by ptr, priority-encoding, then rotating back.
- Top level holds the output register, the ptr update and the tag/payload muxing.

Test Plan:
- Reset: assert reset 2 cycles with all inputs valid -> ostream_val=0 and all istream_rdy=0 during reset; first grant after reset goes to input 0.
- Round-robin saturation (N=8, all val=1, input i sends 32'h100+i, ostream_rdy=1) -> output sequence 0x100..0x107 then 0x100, one per cycle; with TAG_EN the top 3 bits equal 0..7.
- Sparse/wrap: only inputs 2 and 7 valid, ptr=3 -> grant 7, then ptr=0 -> grant 2, then ptr=3 -> grant 7.
- Backpressure: ostream_rdy=0 for 4 cycles with output full -> ostream_msg constant, all istream_rdy=0, ptr unchanged; on release, drain and new grant occur in the same cycle.
- Single requester: only input 5 valid with 10 back-to-back messages -> all accepted at 1/cycle, in order, ptr=6 after each transfer.
- Reset mid-operation: output full with ostream_rdy=0, assert reset 1 cycle -> ostream_val=0 next cycle, message discarded, ptr=0.
